// File: rtl/runway_arbiter.sv
// Runway arbiter: pops take-off/landing requests, binds each aircraft to a free
// runway, hands the grant to the reply sender and tracks ownership until release.
module runway_arbiter #(
    parameter int ID_W            = 4,
    parameter int LAND_STREAK_MAX = 3,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            to_valid,
    input  logic [ID_W-1:0] to_id,
    output logic            to_ready,
    input  logic            ld_valid,
    input  logic [ID_W-1:0] ld_id,
    output logic            ld_ready,
    input  logic            rel_valid,
    input  logic [ID_W-1:0] rel_id,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_runway,
    output logic            grant_landing,
    input  logic            grant_ready,
    output logic [1:0]      runway_active,
    output logic [1:0]      runway_timeout,
    output logic            rel_err
);

    localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int STK_W = (LAND_STREAK_MAX < 1) ? 1 : $clog2(LAND_STREAK_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_TRIP = TMR_W'(TIMEOUT_CYCLES - 2);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(LAND_STREAK_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   owner [2];
    logic [TMR_W-1:0]  timer [2];
    logic [STK_W-1:0]  streak;

    logic              decide;
    logic              pick_to;
    logic              pick_rwy;
    logic [ID_W-1:0]   pick_id;
    logic [1:0]        rel_hit;

    // Decision looks only at registered ownership, so a runway freed this
    // cycle is not offered until the next one.
    always_comb begin
        decide   = (state == IDLE) && (runway_active != 2'b11) && (ld_valid || to_valid);
        pick_to  = to_valid && (!ld_valid || (streak == STK_MAX));
        pick_rwy = runway_active[0];
        pick_id  = pick_to ? to_id : ld_id;
        to_ready = decide && pick_to;
        ld_ready = decide && !pick_to;
        for (int unsigned r = 0; r < 2; r++) begin
            rel_hit[r] = rel_valid && runway_active[r] && (owner[r] == rel_id);
        end
    end

    assign grant_valid = (state == GRANT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            grant_id       <= '0;
            grant_runway   <= 1'b0;
            grant_landing  <= 1'b0;
            runway_active  <= '0;
            runway_timeout <= '0;
            rel_err        <= 1'b0;
            streak         <= '0;
            for (int unsigned r = 0; r < 2; r++) begin
                owner[r] <= '0;
                timer[r] <= '0;
            end
        end else begin
            rel_err <= rel_valid && (rel_hit == 2'b00);

            for (int unsigned r = 0; r < 2; r++) begin
                if (rel_hit[r]) begin
                    runway_active[r]  <= 1'b0;
                    runway_timeout[r] <= 1'b0;
                    timer[r]          <= '0;
                end else if (runway_active[r]) begin
                    if (timer[r] != TMR_MAX) begin
                        timer[r] <= timer[r] + 1'b1;
                    end
                    if (timer[r] == TMR_TRIP) begin
                        runway_timeout[r] <= 1'b1;
                    end
                end
            end

            // The allocated runway is inactive, so it never collides with the
            // release/timer updates above.
            case (state)
                IDLE: begin
                    if (decide) begin
                        grant_id                <= pick_id;
                        grant_runway            <= pick_rwy;
                        grant_landing           <= !pick_to;
                        runway_active[pick_rwy] <= 1'b1;
                        owner[pick_rwy]         <= pick_id;
                        timer[pick_rwy]         <= '0;
                        if (pick_to || !to_valid) begin
                            streak <= '0;
                        end else if (streak != STK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_runway_arbiter.sv
// Directed self-checking bench for runway_arbiter; inputs driven and outputs
// sampled around the falling edge.
module tb_runway_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       to_valid = 1'b0;
    logic [3:0] to_id = '0;
    logic       to_ready;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_id = '0;
    logic       ld_ready;
    logic       rel_valid = 1'b0;
    logic [3:0] rel_id = '0;
    logic       grant_valid;
    logic [3:0] grant_id;
    logic       grant_runway;
    logic       grant_landing;
    logic       grant_ready = 1'b0;
    logic [1:0] runway_active;
    logic [1:0] runway_timeout;
    logic       rel_err;

    int checks = 0;
    int errors = 0;

    runway_arbiter #(
        .ID_W           (4),
        .LAND_STREAK_MAX(3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .to_valid      (to_valid),
        .to_id         (to_id),
        .to_ready      (to_ready),
        .ld_valid      (ld_valid),
        .ld_id         (ld_id),
        .ld_ready      (ld_ready),
        .rel_valid     (rel_valid),
        .rel_id        (rel_id),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .grant_runway  (grant_runway),
        .grant_landing (grant_landing),
        .grant_ready   (grant_ready),
        .runway_active (runway_active),
        .runway_timeout(runway_timeout),
        .rel_err       (rel_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] id, input logic rwy, input logic land);
        chk({tag, ".valid"}, 32'(grant_valid), 32'd1);
        chk({tag, ".id"}, 32'(grant_id), 32'(id));
        chk({tag, ".runway"}, 32'(grant_runway), 32'(rwy));
        chk({tag, ".landing"}, 32'(grant_landing), 32'(land));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".outs"},
            32'({to_ready, ld_ready, grant_valid, grant_id, grant_runway, grant_landing,
                 runway_active, runway_timeout, rel_err}), 32'd0);
    endtask

    // One request served on runway 0; the aircraft releases while its grant is pending.
    task automatic serve(input logic [3:0] eid, input logic eland, input bit last);
        chk("serve.ld_ready", 32'(ld_ready), 32'(eland));
        chk("serve.to_ready", 32'(to_ready), 32'(!eland));
        @(negedge clock);
        if (eland) ld_id = ld_id + 4'd1;
        else       to_id = to_id + 4'd1;
        grant_ready = 1'b1;
        rel_valid   = 1'b1;
        rel_id      = eid;
        #1;
        chk_grant("serve", eid, 1'b0, eland);
        @(negedge clock);
        grant_ready = 1'b0;
        rel_valid   = 1'b0;
        if (last) begin
            ld_valid = 1'b0;
            to_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk_quiet("reset");

        // Simultaneous landing and take-off with both runways free.
        @(negedge clock);
        reset_n = 1'b1;
        ld_valid = 1'b1; ld_id = 4'd5;
        to_valid = 1'b1; to_id = 4'd9;
        #1;
        chk("s1.ld_ready", 32'(ld_ready), 32'd1);
        chk("s1.to_ready", 32'(to_ready), 32'd0);
        @(negedge clock);
        ld_valid = 1'b0; grant_ready = 1'b1;
        #1;
        chk_grant("s1.g5", 4'd5, 1'b0, 1'b1);
        chk("s1.active", 32'(runway_active), 32'b01);
        chk("s1.no_pop", 32'(to_ready), 32'd0);
        @(negedge clock);
        grant_ready = 1'b0;
        #1;
        chk("s1.idle", 32'(grant_valid), 32'd0);
        chk("s1.to_ready", 32'(to_ready), 32'd1);
        @(negedge clock);
        to_valid = 1'b0; grant_ready = 1'b1;
        #1;
        chk_grant("s1.g9", 4'd9, 1'b1, 1'b0);
        chk("s1.active2", 32'(runway_active), 32'b11);

        // Both runways owned: nothing pops until a release lands.
        @(negedge clock);
        grant_ready = 1'b0;
        ld_valid = 1'b1; ld_id = 4'd1;
        to_valid = 1'b1; to_id = 4'd7;
        #1;
        chk("full.ld_ready", 32'(ld_ready), 32'd0);
        chk("full.to_ready", 32'(to_ready), 32'd0);
        @(negedge clock);
        rel_valid = 1'b1; rel_id = 4'd5;
        #1;
        chk("full.rel_cycle_ready", 32'({ld_ready, to_ready}), 32'd0);
        @(negedge clock);
        rel_valid = 1'b0;
        #1;
        chk("full.active", 32'(runway_active), 32'b10);
        chk("full.rel_err", 32'(rel_err), 32'd0);

        // Landing streak of 3 lets the waiting take-off through.
        serve(4'd1, 1'b1, 1'b0);
        serve(4'd2, 1'b1, 1'b0);
        serve(4'd3, 1'b1, 1'b0);
        serve(4'd7, 1'b0, 1'b0);
        serve(4'd4, 1'b1, 1'b1);

        // Runway 1 has been held long enough to time out; runway 0 has not.
        chk("to.pre_timeout", 32'(runway_timeout), 32'b10);
        chk("to.pre_active", 32'(runway_active), 32'b10);
        @(negedge clock);
        ld_valid = 1'b1; ld_id = 4'd6;
        #1;
        chk("to.ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clock);
        ld_valid = 1'b0; grant_ready = 1'b1;
        #1;
        chk_grant("to.g6", 4'd6, 1'b0, 1'b1);
        chk("to.cycle1", 32'(runway_timeout[0]), 32'd0);
        for (int i = 2; i <= 7; i++) begin
            @(negedge clock);
            grant_ready = 1'b0;
            #1;
            chk($sformatf("to.cycle%0d", i), 32'(runway_timeout[0]), 32'd0);
        end
        @(negedge clock);
        #1;
        chk("to.cycle8", 32'(runway_timeout[0]), 32'd1);
        @(negedge clock);
        rel_valid = 1'b1; rel_id = 4'd6;
        #1;
        chk("to.sticky", 32'(runway_timeout), 32'b11);

        // Release clears ownership and timeout; unknown id flags rel_err.
        @(negedge clock);
        rel_id = 4'd12;
        #1;
        chk("rel.timeout_clr", 32'(runway_timeout), 32'b10);
        chk("rel.active_clr", 32'(runway_active), 32'b10);
        chk("rel.err_low", 32'(rel_err), 32'd0);
        @(negedge clock);
        rel_id = 4'd9;
        #1;
        chk("rel.err_pulse", 32'(rel_err), 32'd1);
        chk("rel.err_active", 32'(runway_active), 32'b10);
        @(negedge clock);
        rel_valid = 1'b0;
        #1;
        chk("rel.err_end", 32'(rel_err), 32'd0);
        chk("rel.all_free", 32'({runway_active, runway_timeout}), 32'd0);

        // Reply sender stalls: grant holds, nothing pops despite a free runway.
        @(negedge clock);
        ld_valid = 1'b1; ld_id = 4'd2;
        #1;
        chk("hold.ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clock);
        ld_id = 4'd3; to_valid = 1'b1; to_id = 4'd8;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk_grant("hold", 4'd2, 1'b0, 1'b1);
            chk("hold.no_pop", 32'({ld_ready, to_ready}), 32'd0);
            @(negedge clock);
        end
        grant_ready = 1'b1;
        #1;
        chk("hold.last", 32'(grant_valid), 32'd1);
        @(negedge clock);
        grant_ready = 1'b0;
        #1;
        chk("hold.idle", 32'(grant_valid), 32'd0);
        chk("hold.land_wins", 32'({ld_ready, to_ready}), 32'b10);
        @(negedge clock);
        ld_valid = 1'b0; to_valid = 1'b0;
        #1;
        chk_grant("hold.g3", 4'd3, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a pending grant.
        #1;
        reset_n = 1'b0;
        #1;
        chk_quiet("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        ld_valid = 1'b1; ld_id = 4'd11;
        #1;
        chk("post.ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clock);
        ld_valid = 1'b0;
        #1;
        chk_grant("post.g11", 4'd11, 1'b0, 1'b1);
        chk("post.active", 32'(runway_active), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
